// File: rtl/contour_paddle_tracker.sv
// contour_paddle_tracker
//   Tracks the vertical extent of contour pixels inside a column window
//   (the player region) over each video frame. At frame end it reports the
//   top, bottom and centre row of that extent as the paddle position.
//   Input is one pixel per valid cycle in raster order.
//
// Ports
//   clk        clock
//   rst        reset, asynchronous, active-high
//   iValid     iContour / iSOF valid this cycle
//   iSOF       first pixel of frame (x=0, y=0), qualified by iValid
//   iContour   contour value (0 or 255 typical)
//   oPaddleY   centre row of tracked contour
//   oTop       min hit row of last locked frame
//   oBottom    max hit row of last locked frame
//   oLock      last reported frame had >= MIN_PIX hits
//   oPosValid  one-cycle pulse: new frame report
//   oFrameErr  one-cycle pulse: frame abandoned by an early iSOF
module contour_paddle_tracker #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ROI_X0   = 0,
  parameter int ROI_X1   = 63,
  parameter int THRESH   = 128,
  parameter int MIN_PIX  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iValid,
  input  logic       iSOF,
  input  logic [9:0] iContour,
  output logic [9:0] oPaddleY,
  output logic [9:0] oTop,
  output logic [9:0] oBottom,
  output logic       oLock,
  output logic       oPosValid,
  output logic       oFrameErr
);

  localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  Y_CENTRE = 10'(V_ACTIVE / 2);
  localparam logic [18:0] MIN_CNT  = 19'(MIN_PIX);

  typedef enum logic [1:0] {WAIT_SOF, ACCUM, REPORT} state_t;

  state_t      state_reg;
  logic [9:0]  x_reg;
  logic [9:0]  y_reg;
  logic [9:0]  min_y_reg;
  logic [9:0]  max_y_reg;
  logic [18:0] count_reg;

  logic        start;
  logic        take;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        in_roi;
  logic        hit;
  logic [18:0] base_count;
  logic [9:0]  base_min;
  logic [9:0]  base_max;
  logic [18:0] count_next;
  logic [9:0]  min_y_next;
  logic [9:0]  max_y_next;
  logic        last_col;
  logic        last_row;
  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic [10:0] y_sum;

  always_comb begin
    start = iValid & iSOF;
    // A pixel is consumed on SOF from idle/report, or on any valid cycle
    // mid-frame. Non-SOF pixels arriving in WAIT_SOF or REPORT are dropped.
    take  = ((state_reg == WAIT_SOF) && start) ||
            ((state_reg == ACCUM)    && iValid) ||
            ((state_reg == REPORT)   && start);

    // An accepted SOF always means pixel (0,0) of a fresh frame, so the
    // accumulators restart from their cleared values for this pixel.
    px = start ? 10'd0 : x_reg;
    py = start ? 10'd0 : y_reg;

    // Signed compares keep a zero ROI_X0 from producing a constant compare.
    in_roi = (int'(px) >= ROI_X0) && (int'(px) <= ROI_X1);
    hit    = iValid && (int'(iContour) >= THRESH) && in_roi;

    base_count = start ? 19'd0 : count_reg;
    base_min   = start ? V_LAST : min_y_reg;
    base_max   = start ? 10'd0 : max_y_reg;

    count_next = base_count + 19'(hit);
    min_y_next = (hit && (py < base_min)) ? py : base_min;
    max_y_next = (hit && (py > base_max)) ? py : base_max;

    last_col = (px == H_LAST);
    last_row = (py == V_LAST);
    x_next   = last_col ? 10'd0 : px + 10'd1;
    y_next   = last_col ? (last_row ? 10'd0 : py + 10'd1) : py;

    // 11-bit sum so the centre never wraps before the shift.
    y_sum = {1'b0, min_y_reg} + {1'b0, max_y_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WAIT_SOF;
      x_reg     <= 10'd0;
      y_reg     <= 10'd0;
      min_y_reg <= V_LAST;
      max_y_reg <= 10'd0;
      count_reg <= 19'd0;
      oPaddleY  <= Y_CENTRE;
      oTop      <= 10'd0;
      oBottom   <= 10'd0;
      oLock     <= 1'b0;
      oPosValid <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      oPosValid <= 1'b0;
      oFrameErr <= 1'b0;

      if (take) begin
        count_reg <= count_next;
        min_y_reg <= min_y_next;
        max_y_reg <= max_y_next;
        x_reg     <= x_next;
        y_reg     <= y_next;
        state_reg <= (last_col && last_row) ? REPORT : ACCUM;
      end else if (state_reg == REPORT) begin
        count_reg <= 19'd0;
        min_y_reg <= V_LAST;
        max_y_reg <= 10'd0;
        x_reg     <= 10'd0;
        y_reg     <= 10'd0;
        state_reg <= WAIT_SOF;
      end

      // The report is built from the accumulators of the frame just ended;
      // a back-to-back SOF in this cycle only affects the next frame.
      if (state_reg == REPORT) begin
        oPosValid <= 1'b1;
        if (count_reg >= MIN_CNT) begin
          oTop     <= min_y_reg;
          oBottom  <= max_y_reg;
          oPaddleY <= y_sum[10:1];
          oLock    <= 1'b1;
        end else begin
          oLock    <= 1'b0;
        end
      end

      if ((state_reg == ACCUM) && start && ((x_reg != 10'd0) || (y_reg != 10'd0)))
        oFrameErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_contour_paddle_tracker.sv
// tb_contour_paddle_tracker
//   Directed bench for contour_paddle_tracker with a reduced frame size
//   (40 x 142) and a column window of 4..31 so full frames stay short.
module tb_contour_paddle_tracker;

  localparam int H   = 40;
  localparam int V   = 142;
  localparam int X0  = 4;
  localparam int X1  = 31;
  localparam int NPX = H * V;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iValid = 1'b0;
  logic       iSOF = 1'b0;
  logic [9:0] iContour = 10'd0;
  logic [9:0] oPaddleY, oTop, oBottom;
  logic       oLock, oPosValid, oFrameErr;

  contour_paddle_tracker #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ROI_X0(X0), .ROI_X1(X1),
    .THRESH(128), .MIN_PIX(16)
  ) dut (
    .clk(clk), .rst(rst), .iValid(iValid), .iSOF(iSOF), .iContour(iContour),
    .oPaddleY(oPaddleY), .oTop(oTop), .oBottom(oBottom), .oLock(oLock),
    .oPosValid(oPosValid), .oFrameErr(oFrameErr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  always @(posedge clk) cyc++;

  // Report capture: one entry per oPosValid pulse.
  int         pv_cnt = 0;
  int         fe_cnt = 0;
  int         fe_cyc = 0;
  int         rep_cyc [16];
  logic [9:0] rep_pad [16];
  logic [9:0] rep_top [16];
  logic [9:0] rep_bot [16];
  logic       rep_lock[16];

  always @(negedge clk) begin
    if (oPosValid === 1'b1) begin
      if (pv_cnt < 16) begin
        rep_cyc[pv_cnt]  = cyc;
        rep_pad[pv_cnt]  = oPaddleY;
        rep_top[pv_cnt]  = oTop;
        rep_bot[pv_cnt]  = oBottom;
        rep_lock[pv_cnt] = oLock;
      end
      pv_cnt++;
    end
    if (oFrameErr === 1'b1) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pixel value for each test picture; non-hit pixels get random sub-threshold noise.
  function automatic logic [9:0] pix(input int kind, input int x, input int y);
    logic [9:0] v;
    logic [9:0] hv;
    v  = 10'($urandom_range(127));
    hv = (y % 3 == 0) ? 10'd128 : ((y % 3 == 1) ? 10'd255 : 10'd1023);
    case (kind)
      2: if (x == 20 && y >= 100 && y <= 139) v = hv;
      3: if ((x == 4 && y == 5) || (x == 31 && y == 6) || (x == 20 && y == 7)) v = 10'd255;
      4: begin
        if (x == 3 || x == 32 || x == 36) v = 10'd255;
        else if (x == 20) v = 10'd127;
        else if (x == 25 && y >= 60 && y <= 74) v = 10'd255;
      end
      5: if (x == 20 && y >= 10 && y <= 40) v = 10'd255;
      7: if (x == 20 && y < 16) v = 10'd255;
      default: ;
    endcase
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      iValid = 1'b0; iSOF = 1'b0; iContour = 10'd0;
    end
  endtask

  // Drives npix pixels in raster order from (0,0); the last one is left on
  // the bus, so the caller follows with idle() or another frame.
  task automatic send_frame(input int kind, input bit gaps, input int npix, input bit sof);
    for (int i = 0; i < npix; i++) begin
      if (gaps) begin
        while ($urandom_range(1) == 1) begin
          @(posedge clk); #1;
          iValid = 1'b0; iSOF = 1'($urandom_range(1)); iContour = 10'($urandom_range(1023));
        end
      end
      @(posedge clk); #1;
      iValid = 1'b1;
      iSOF = (sof && i == 0);
      iContour = pix(kind, i % H, i / H);
      if (i == 0) first_cyc = cyc;
    end
    last_cyc = cyc;
  endtask

  task automatic chk_report(input string tag, input int idx, input int lc,
                            input int pad, input int top, input int bot, input bit lock);
    chk({tag, "_cyc"},  rep_cyc[idx], lc + 2);
    chk({tag, "_pad"},  rep_pad[idx], pad);
    chk({tag, "_top"},  rep_top[idx], top);
    chk({tag, "_bot"},  rep_bot[idx], bot);
    chk({tag, "_lock"}, rep_lock[idx], lock);
  endtask

  int last2, last3, sof5;

  initial begin
    // 1: reset values (checked while rst is high, before any clock edge).
    #1 rst = 1'b1;
    #1;
    chk("rst_pad", oPaddleY, V / 2);
    chk("rst_top", oTop, 0);
    chk("rst_bot", oBottom, 0);
    chk("rst_lock", oLock, 0);
    chk("rst_pv", oPosValid, 0);
    chk("rst_fe", oFrameErr, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(3);

    // 2 + 3: locked frame, then a 3-hit frame starting in the REPORT cycle.
    send_frame(2, 1'b0, NPX, 1'b1);
    last2 = last_cyc;
    send_frame(3, 1'b0, NPX, 1'b1);
    last3 = last_cyc;
    idle(2); @(negedge clk); #1;
    chk("f23_pvcnt", pv_cnt, 2);
    chk_report("f2", 0, last2, 119, 100, 139, 1'b1);
    chk_report("f3", 1, last3, 119, 100, 139, 1'b0);
    @(posedge clk); #1;
    chk("f3_pulse_end", oPosValid, 0);

    // 4: hits only outside the window, sub-threshold inside, 15 real hits.
    idle(4);
    send_frame(4, 1'b0, NPX, 1'b1);
    idle(2); @(negedge clk); #1;
    chk("f4_pvcnt", pv_cnt, 3);
    chk_report("f4", 2, last_cyc, 119, 100, 139, 1'b0);
    $display("[TB] frame 4 report: pad=%0d top=%0d bot=%0d lock=%0d",
             rep_pad[2], rep_top[2], rep_bot[2], rep_lock[2]);

    // 5: abandon a frame with an SOF at (10,50), then a full frame.
    idle(3);
    send_frame(5, 1'b0, 50 * H + 10, 1'b1);
    send_frame(2, 1'b0, NPX, 1'b1);
    sof5 = first_cyc;
    idle(2); @(negedge clk); #1;
    chk("f5_fecnt", fe_cnt, 1);
    chk("f5_fecyc", fe_cyc, sof5 + 1);
    chk("f5_pvcnt", pv_cnt, 4);
    chk_report("f5", 3, last_cyc, 119, 100, 139, 1'b1);

    // 6: same picture with random valid gaps and stray iSOF on idle cycles.
    send_frame(2, 1'b1, NPX, 1'b1);
    idle(2); @(negedge clk); #1;
    chk("f6_pvcnt", pv_cnt, 5);
    chk("f6_fecnt", fe_cnt, 1);
    chk_report("f6", 4, last_cyc, 119, 100, 139, 1'b1);

    // Reset mid-frame: discarded, then non-SOF pixels are ignored.
    idle(2);
    send_frame(7, 1'b0, 101 * H + 25, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pad", oPaddleY, V / 2);
    chk("mid_rst_top", oTop, 0);
    chk("mid_rst_bot", oBottom, 0);
    chk("mid_rst_lock", oLock, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(7, 1'b0, 2 * H, 1'b0);
    idle(4); @(negedge clk); #1;
    chk("mid_rst_pvcnt", pv_cnt, 5);
    chk("mid_rst_fecnt", fe_cnt, 1);

    // Exactly MIN_PIX hits after reset.
    send_frame(7, 1'b0, NPX, 1'b1);
    idle(2); @(negedge clk); #1;
    chk("f7_pvcnt", pv_cnt, 6);
    chk("f7_fecnt", fe_cnt, 1);
    chk_report("f7", 5, last_cyc, 7, 0, 15, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
